// File: rtl/instruction_fetch_unit_if.sv
// Instruction-memory request bus between the fetch unit (master) and instruction memory (slave).
// The request holds address stable from assertion until the cycle the memory signals ready.

interface instruction_fetch_unit_if;
    logic        IMemReq_o;
    logic [31:0] IMemAddr_o;
    logic        IMemReady_i;
    logic [31:0] IMemData_i;

    modport master (
        output IMemReq_o,
        output IMemAddr_o,
        input  IMemReady_i,
        input  IMemData_i
    );

    modport slave (
        input  IMemReq_o,
        input  IMemAddr_o,
        output IMemReady_i,
        output IMemData_i
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// MIPS instruction fetch stage: PC, instruction-memory handshake, one-entry skid buffer and IF/ID register.
// Optional build macro FETCH_COUNTER_EN adds FetchCount_o, a count of fetched words that were kept.

module instruction_fetch_unit #(
    parameter logic [31:0] PC_RESET = 32'h0040_0000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     Stall_i,
    input  logic                     BranchTaken_i,
    input  logic [31:0]              BranchTarget_i,
    instruction_fetch_unit_if.master imem,
    output logic [31:0]              Instruction_o,
    output logic [5:0]               OP_o,
    output logic [31:0]              PCPlus4_o,
    output logic                     Valid_o
`ifdef FETCH_COUNTER_EN
    ,
    output logic [31:0]              FetchCount_o
`endif
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        DROP  = 2'd2
    } state_t;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return a & 32'hFFFF_FFFC;
    endfunction

    function automatic logic [31:0] pc_inc(input logic [31:0] a);
        return a + 32'd4;
    endfunction

    state_t      state_r, state_s;
    logic [31:0] pc_r, pc_s;
    logic [31:0] target_r, target_s;
    logic        req_r, req_s;
    logic [31:0] addr_r, addr_s;
    logic        skid_valid_r, skid_valid_s;
    logic [31:0] skid_instr_r, skid_instr_s;
    logic [31:0] skid_pc4_r, skid_pc4_s;
    logic        ifid_valid_r, ifid_valid_s;
    logic [31:0] ifid_instr_r, ifid_instr_s;
    logic [31:0] ifid_pc4_r, ifid_pc4_s;
    logic        hs_s;
    logic        keep_s;
    logic [31:0] target_in_s;

    assign hs_s        = req_r & imem.IMemReady_i;
    assign target_in_s = word_align(BranchTarget_i);

    // State register and all datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= BOOT;
            pc_r         <= PC_RESET;
            target_r     <= PC_RESET;
            req_r        <= 1'b0;
            addr_r       <= PC_RESET;
            skid_valid_r <= 1'b0;
            skid_instr_r <= 32'd0;
            skid_pc4_r   <= 32'd0;
            ifid_valid_r <= 1'b0;
            ifid_instr_r <= 32'd0;
            ifid_pc4_r   <= 32'd0;
        end else begin
            state_r      <= state_s;
            pc_r         <= pc_s;
            target_r     <= target_s;
            req_r        <= req_s;
            addr_r       <= addr_s;
            skid_valid_r <= skid_valid_s;
            skid_instr_r <= skid_instr_s;
            skid_pc4_r   <= skid_pc4_s;
            ifid_valid_r <= ifid_valid_s;
            ifid_instr_r <= ifid_instr_s;
            ifid_pc4_r   <= ifid_pc4_s;
        end
    end

    // Next state, next PC, redirect target latch and keep decision for the memory word
    always_comb begin
        state_s  = state_r;
        pc_s     = pc_r;
        target_s = target_r;
        keep_s   = 1'b0;
        case (state_r)
            BOOT: begin
                state_s = FETCH;
                if (BranchTaken_i) begin
                    pc_s     = target_in_s;
                    target_s = target_in_s;
                end else begin
                    pc_s = pc_r;
                end
            end
            FETCH: begin
                if (BranchTaken_i) begin
                    target_s = target_in_s;
                    if (req_r && !imem.IMemReady_i) begin
                        state_s = DROP;
                    end else begin
                        pc_s    = target_in_s;
                        state_s = FETCH;
                    end
                end else if (hs_s) begin
                    pc_s   = pc_inc(pc_r);
                    keep_s = 1'b1;
                end else begin
                    pc_s = pc_r;
                end
            end
            DROP: begin
                if (BranchTaken_i) begin
                    target_s = target_in_s;
                end else begin
                    target_s = target_r;
                end
                // The stale word is thrown away; a redirect in the same cycle wins
                if (hs_s) begin
                    pc_s    = target_s;
                    state_s = FETCH;
                end else begin
                    state_s = DROP;
                end
            end
            default: begin
                state_s  = BOOT;
                pc_s     = PC_RESET;
                target_s = PC_RESET;
            end
        endcase
    end

    // IF/ID register and skid buffer next values
    always_comb begin
        skid_valid_s = skid_valid_r;
        skid_instr_s = skid_instr_r;
        skid_pc4_s   = skid_pc4_r;
        ifid_valid_s = ifid_valid_r;
        ifid_instr_s = ifid_instr_r;
        ifid_pc4_s   = ifid_pc4_r;
        if (BranchTaken_i) begin
            ifid_valid_s = 1'b0;
            ifid_instr_s = 32'd0;
            ifid_pc4_s   = 32'd0;
            skid_valid_s = 1'b0;
            skid_instr_s = 32'd0;
            skid_pc4_s   = 32'd0;
        end else if (!Stall_i) begin
            if (skid_valid_r) begin
                ifid_valid_s = 1'b1;
                ifid_instr_s = skid_instr_r;
                ifid_pc4_s   = skid_pc4_r;
                skid_valid_s = 1'b0;
                skid_instr_s = 32'd0;
                skid_pc4_s   = 32'd0;
            end else if (keep_s) begin
                ifid_valid_s = 1'b1;
                ifid_instr_s = imem.IMemData_i;
                ifid_pc4_s   = pc_inc(addr_r);
            end else begin
                ifid_valid_s = 1'b0;
                ifid_instr_s = 32'd0;
                ifid_pc4_s   = 32'd0;
            end
        end else if (keep_s && !ifid_valid_r) begin
            ifid_valid_s = 1'b1;
            ifid_instr_s = imem.IMemData_i;
            ifid_pc4_s   = pc_inc(addr_r);
        end else if (keep_s) begin
            skid_valid_s = 1'b1;
            skid_instr_s = imem.IMemData_i;
            skid_pc4_s   = pc_inc(addr_r);
        end else begin
            skid_valid_s = skid_valid_r;
            ifid_valid_s = ifid_valid_r;
        end
    end

    // Request generation: an unanswered request is frozen, otherwise fetch whenever the skid is free
    always_comb begin
        req_s  = 1'b0;
        addr_s = pc_s;
        if (req_r && !hs_s) begin
            req_s  = 1'b1;
            addr_s = addr_r;
        end else if ((state_s == FETCH) && !skid_valid_s) begin
            req_s  = 1'b1;
            addr_s = pc_s;
        end else begin
            req_s  = 1'b0;
            addr_s = pc_s;
        end
    end

    assign imem.IMemReq_o  = req_r;
    assign imem.IMemAddr_o = addr_r;
    assign Instruction_o   = ifid_instr_r;
    assign OP_o            = ifid_instr_r[31:26];
    assign PCPlus4_o       = ifid_pc4_r;
    assign Valid_o         = ifid_valid_r;

`ifdef FETCH_COUNTER_EN
    logic [31:0] count_r;

    // Count of handshaked words that were kept
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_r <= 32'd0;
        end else begin
            count_r <= count_r + {31'd0, keep_s};
        end
    end

    assign FetchCount_o = count_r;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed scenarios plus a scoreboard of kept fetches.
// Memory returns a word derived from its address with a programmable number of wait cycles.

module tb_instruction_fetch_unit;
    localparam logic [31:0] PC_RESET = 32'h0040_0000;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
    } sb_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        Stall_i;
    logic        BranchTaken_i;
    logic [31:0] BranchTarget_i;
    logic [31:0] Instruction_o;
    logic [5:0]  OP_o;
    logic [31:0] PCPlus4_o;
    logic        Valid_o;
`ifdef FETCH_COUNTER_EN
    logic [31:0] FetchCount_o;
`endif

    instruction_fetch_unit_if bus();

    instruction_fetch_unit dut (
        .clk           (clk),
        .reset         (reset),
        .Stall_i       (Stall_i),
        .BranchTaken_i (BranchTaken_i),
        .BranchTarget_i(BranchTarget_i),
        .imem          (bus),
        .Instruction_o (Instruction_o),
        .OP_o          (OP_o),
        .PCPlus4_o     (PCPlus4_o),
        .Valid_o       (Valid_o)
`ifdef FETCH_COUNTER_EN
        ,
        .FetchCount_o  (FetchCount_o)
`endif
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_bad = 0;
    int          wait_cfg = 0;
    bit          mem_hold = 1'b0;
    sb_t         sb[$];
    logic [31:0] exp_pc = PC_RESET;
    logic [31:0] kept = 32'd0;
    bit          drop_pend = 1'b0;
    bit          prev_st = 1'b0;
    bit          prev_v = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h1234, a[31:16]};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Instruction memory model with programmable wait cycles
    initial begin : memory
        int cnt;
        cnt = 0;
        bus.IMemReady_i = 1'b0;
        bus.IMemData_i  = 32'd0;
        forever begin
            @(negedge clk);
            #1;
            if (!bus.IMemReq_o || mem_hold) begin
                bus.IMemReady_i = 1'b0;
                cnt = 0;
            end else if (cnt >= wait_cfg) begin
                bus.IMemReady_i = 1'b1;
                bus.IMemData_i  = mem_word(bus.IMemAddr_o);
                cnt = 0;
            end else begin
                bus.IMemReady_i = 1'b0;
                cnt++;
            end
        end
    end

    // Scoreboard: evaluated just before each rising edge
    initial begin : monitor
        sb_t  e;
        logic hs;
        forever begin
            @(negedge clk);
            #4;
            if (!reset) begin
                sb.delete();
                exp_pc    = PC_RESET;
                drop_pend = 1'b0;
                kept      = 32'd0;
                prev_st   = 1'b0;
                prev_v    = 1'b0;
            end else begin
                if (Valid_o && !(prev_st && prev_v)) begin
                    if (sb.size() == 0) begin
                        check_eq("sb_depth", 32'(sb.size()), 32'd1);
                    end else begin
                        e = sb.pop_front();
                        check_eq("sb_instr", Instruction_o, e.instr);
                        check_eq("sb_op", 32'(OP_o), 32'(e.instr[31:26]));
                        check_eq("sb_pc4", PCPlus4_o, e.pc4);
                    end
                end else if (!Valid_o) begin
                    check_eq("bubble", Instruction_o, 32'd0);
                end
`ifdef FETCH_COUNTER_EN
                check_eq("fetch_count", FetchCount_o, kept);
`endif
                hs = bus.IMemReq_o && bus.IMemReady_i;
                if (BranchTaken_i) begin
                    sb.delete();
                    drop_pend = bus.IMemReq_o && !hs;
                    exp_pc    = BranchTarget_i & 32'hFFFF_FFFC;
                end else if (hs) begin
                    if (drop_pend) begin
                        drop_pend = 1'b0;
                    end else begin
                        check_eq("fetch_addr", bus.IMemAddr_o, exp_pc);
                        sb.push_back(sb_t'({mem_word(exp_pc), exp_pc + 32'd4}));
                        exp_pc = exp_pc + 32'd4;
                        kept   = kept + 32'd1;
                    end
                end
                prev_st = Stall_i;
                prev_v  = Valid_o;
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "run did not complete");
    end

    initial begin : stimulus
        reset          = 1'b0;
        Stall_i        = 1'b0;
        BranchTaken_i  = 1'b0;
        BranchTarget_i = 32'd0;
        tick(2);
        check_eq("rst_req", 32'(bus.IMemReq_o), 32'd0);
        check_eq("rst_addr", bus.IMemAddr_o, PC_RESET);
        check_eq("rst_instr", Instruction_o, 32'd0);
        check_eq("rst_op", 32'(OP_o), 32'd0);
        check_eq("rst_pc4", PCPlus4_o, 32'd0);
        check_eq("rst_valid", 32'(Valid_o), 32'd0);

        // zero-wait stream after reset release
        reset = 1'b1;
        tick(1);
        check_eq("c1_req", 32'(bus.IMemReq_o), 32'd1);
        check_eq("c1_addr", bus.IMemAddr_o, 32'h0040_0000);
        check_eq("c1_valid", 32'(Valid_o), 32'd0);
        tick(1);
        check_eq("c2_addr", bus.IMemAddr_o, 32'h0040_0004);
        check_eq("c2_valid", 32'(Valid_o), 32'd1);
        check_eq("c2_instr", Instruction_o, mem_word(32'h0040_0000));
        check_eq("c2_pc4", PCPlus4_o, 32'h0040_0004);
        tick(1);
        check_eq("c3_addr", bus.IMemAddr_o, 32'h0040_0008);

        // three wait cycles
        mem_hold = 1'b1;
        tick(2);
        mem_hold = 1'b0;
        wait_cfg = 3;
        tick(3);
        check_eq("w3_addr_hold", bus.IMemAddr_o, 32'h0040_0008);
        check_eq("w3_req_hold", 32'(bus.IMemReq_o), 32'd1);
        tick(1);
        check_eq("w4_addr", bus.IMemAddr_o, 32'h0040_000C);
        check_eq("w4_valid", 32'(Valid_o), 32'd1);
        check_eq("w4_instr", Instruction_o, mem_word(32'h0040_0008));
        tick(1);
        check_eq("w5_valid", 32'(Valid_o), 32'd0);
        tick(3);
        check_eq("w8_addr", bus.IMemAddr_o, 32'h0040_0010);
        check_eq("w8_valid", 32'(Valid_o), 32'd1);
        check_eq("w8_instr", Instruction_o, mem_word(32'h0040_000C));

        // stall while a request completes: word parks in the skid
        Stall_i  = 1'b1;
        wait_cfg = 0;
        tick(1);
        check_eq("st1_req", 32'(bus.IMemReq_o), 32'd0);
        check_eq("st1_instr", Instruction_o, mem_word(32'h0040_000C));
        tick(1);
        Stall_i = 1'b0;
        check_eq("st2_req", 32'(bus.IMemReq_o), 32'd0);
        check_eq("st2_instr", Instruction_o, mem_word(32'h0040_000C));
        tick(1);
        check_eq("st3_instr", Instruction_o, mem_word(32'h0040_0010));
        check_eq("st3_pc4", PCPlus4_o, 32'h0040_0014);
        check_eq("st3_addr", bus.IMemAddr_o, 32'h0040_0014);
        tick(1);
        check_eq("st4_instr", Instruction_o, mem_word(32'h0040_0014));
        check_eq("st4_addr", bus.IMemAddr_o, 32'h0040_0018);
        wait_cfg = 3;

        // redirect while a request is waiting
        tick(1);
        BranchTaken_i  = 1'b1;
        BranchTarget_i = 32'h0040_0103;
        tick(1);
        BranchTaken_i = 1'b0;
        check_eq("drop_valid", 32'(Valid_o), 32'd0);
        check_eq("drop_instr", Instruction_o, 32'd0);
        check_eq("drop_req", 32'(bus.IMemReq_o), 32'd1);
        check_eq("drop_addr", bus.IMemAddr_o, 32'h0040_0018);
        tick(2);
        check_eq("tgt_addr", bus.IMemAddr_o, 32'h0040_0100);
        check_eq("tgt_req", 32'(bus.IMemReq_o), 32'd1);
        check_eq("tgt_valid0", 32'(Valid_o), 32'd0);
        tick(2);
        check_eq("tgt_valid1", 32'(Valid_o), 32'd0);
        tick(2);
        check_eq("tgt_valid", 32'(Valid_o), 32'd1);
        check_eq("tgt_instr", Instruction_o, mem_word(32'h0040_0100));
        check_eq("tgt_pc4", PCPlus4_o, 32'h0040_0104);

        // redirect together with stall and a full skid
        Stall_i  = 1'b1;
        wait_cfg = 0;
        tick(1);
        check_eq("sk_req", 32'(bus.IMemReq_o), 32'd0);
        BranchTaken_i  = 1'b1;
        BranchTarget_i = 32'h0040_0200;
        tick(1);
        check_eq("sk_valid", 32'(Valid_o), 32'd0);
        check_eq("sk_instr", Instruction_o, 32'd0);
        check_eq("sk_req2", 32'(bus.IMemReq_o), 32'd1);
        check_eq("sk_addr", bus.IMemAddr_o, 32'h0040_0200);
        BranchTaken_i = 1'b0;
        Stall_i       = 1'b0;
        tick(1);
        check_eq("sk_valid2", 32'(Valid_o), 32'd1);
        check_eq("sk_instr2", Instruction_o, mem_word(32'h0040_0200));
        check_eq("sk_pc4", PCPlus4_o, 32'h0040_0204);

        // redirect with a same-cycle handshake, then PC wrap
        BranchTaken_i  = 1'b1;
        BranchTarget_i = 32'hFFFF_FFF8;
        tick(1);
        BranchTaken_i = 1'b0;
        check_eq("wr_addr0", bus.IMemAddr_o, 32'hFFFF_FFF8);
        check_eq("wr_valid0", 32'(Valid_o), 32'd0);
        tick(1);
        check_eq("wr_addr1", bus.IMemAddr_o, 32'hFFFF_FFFC);
        check_eq("wr_instr1", Instruction_o, mem_word(32'hFFFF_FFF8));
        tick(1);
        check_eq("wr_addr2", bus.IMemAddr_o, 32'h0000_0000);
        check_eq("wr_instr2", Instruction_o, mem_word(32'hFFFF_FFFC));
        check_eq("wr_pc4", PCPlus4_o, 32'h0000_0000);

        // reset asserted while a request is waiting
        wait_cfg = 3;
        tick(2);
        #2;
        reset = 1'b0;
        #1;
        check_eq("mr_req", 32'(bus.IMemReq_o), 32'd0);
        check_eq("mr_addr", bus.IMemAddr_o, PC_RESET);
        check_eq("mr_valid", 32'(Valid_o), 32'd0);
        check_eq("mr_instr", Instruction_o, 32'd0);
        check_eq("mr_pc4", PCPlus4_o, 32'd0);
`ifdef FETCH_COUNTER_EN
        check_eq("mr_count", FetchCount_o, 32'd0);
`endif
        tick(1);
        reset    = 1'b1;
        wait_cfg = 0;
        tick(1);
        check_eq("rb_req", 32'(bus.IMemReq_o), 32'd1);
        check_eq("rb_addr", bus.IMemAddr_o, PC_RESET);
        tick(1);
        check_eq("rb_addr2", bus.IMemAddr_o, 32'h0040_0004);
        check_eq("rb_valid", 32'(Valid_o), 32'd1);
        check_eq("rb_instr", Instruction_o, mem_word(32'h0040_0000));
        tick(10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
